// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: channel opcodes and the contiguous full-mask helper used by both
// the master and slave ends of the link.
package tlul_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  // Byte lanes covered by a naturally aligned 2^size transfer starting at lane addr_lsb.
  // Sized for buses up to 64 bits; callers truncate to their own lane count.
  function automatic logic [7:0] full_mask(input logic [2:0] size, input logic [2:0] addr_lsb);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << addr_lsb;
  endfunction

endpackage

// File: rtl/tlul_slave_if.sv
// TL-UL A/D channel bundle between a master and a responder.
interface tlul_slave_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned SIZE_W   = 2
);

  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [SIZE_W-1:0]     a_size;
  logic [SOURCE_W-1:0]   a_source;
  logic [ADDR_W-1:0]     a_address;
  logic [DATA_W/8-1:0]   a_mask;
  logic [DATA_W-1:0]     a_data;

  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_opcode;
  logic [1:0]            d_param;
  logic [SIZE_W-1:0]     d_size;
  logic [SOURCE_W-1:0]   d_source;
  logic                  d_sink;
  logic                  d_denied;
  logic                  d_corrupt;
  logic [DATA_W-1:0]     d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt,
           d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt,
           d_data
  );

endinterface

// File: rtl/tlul_slave_regfile.sv
// Word array with per-byte write enables and a registered read port.
module tlul_slave_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W/8-1:0]      i_be,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset: contents survive a bus reset and power up unknown.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(DATA_W / 8); b++) begin
        if (i_be[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) rdata_q <= mem_q[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/tlul_slave.sv
// TL-UL responder backed by a small register file: decodes A beats, holds one D response and
// allows a new A beat on the cycle the pending D beat is taken.
module tlul_slave
  import tlul_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       SOURCE_W  = 4,
  parameter int unsigned       SIZE_W    = 2
) (
  input logic         i_clk,
  input logic         i_reset,
  tlul_slave_if.slave tl
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned LaneW = $clog2(Bytes);
  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned Span  = DEPTH * Bytes;

  typedef enum logic {StIdle, StResp} state_e;

  state_e              state_q, state_d;
  d_opcode_e           d_opcode_q;
  logic [SIZE_W-1:0]   d_size_q;
  logic [SOURCE_W-1:0] d_source_q;
  logic                d_denied_q;

  logic                a_ready, a_fire;
  logic [ADDR_W-1:0]   offset;
  logic [LaneW-1:0]    lane;
  logic [2:0]          size3, lane3;
  logic [Bytes-1:0]    fmask;
  logic [IdxW-1:0]     idx;
  logic                in_range, size_ok, aligned, op_ok, mask_ok, denied;
  logic                is_get, is_put;
  logic                rf_we, rf_re;
  logic [DATA_W-1:0]   rf_rdata;

  logic unused_param;
  assign unused_param = ^tl.a_param;

  assign a_fire = tl.a_valid && a_ready;

  // Request decode
  always_comb begin
    offset   = tl.a_address - BASE_ADDR;
    in_range = (tl.a_address >= BASE_ADDR) && (offset < ADDR_W'(Span));
    size_ok  = tl.a_size <= SIZE_W'(LaneW);
    lane     = tl.a_address[LaneW-1:0];
    size3    = 3'(tl.a_size);
    lane3    = 3'(lane);
    // Wraps to an all-ones low mask for size 3, which is what 64-bit alignment needs.
    aligned  = (lane3 & ((3'd1 << size3) - 3'd1)) == 3'd0;
    fmask    = Bytes'(full_mask(size3, lane3));
    is_get   = tl.a_opcode == GET;
    is_put   = (tl.a_opcode == PUT_FULL) || (tl.a_opcode == PUT_PARTIAL);
    op_ok    = is_get || is_put;
    mask_ok  = (tl.a_opcode != PUT_FULL) || (tl.a_mask == fmask);
    denied   = !(in_range && size_ok && aligned && op_ok && mask_ok);
    idx      = offset[LaneW +: IdxW];
    rf_we    = a_fire && !denied && is_put;
    rf_re    = a_fire && !denied && is_get;
  end

  tlul_slave_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_we    (rf_we),
    .i_re    (rf_re),
    .i_addr  (idx),
    .i_be    (tl.a_mask),
    .i_wdata (tl.a_data),
    .o_rdata (rf_rdata)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (a_fire) state_d = StResp;
      StResp: if (!a_fire && tl.d_ready) state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      d_opcode_q <= ACCESS_ACK;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_denied_q <= 1'b0;
    end else if (a_fire) begin
      d_opcode_q <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      d_size_q   <= tl.a_size;
      d_source_q <= tl.a_source;
      d_denied_q <= denied;
    end
  end

  // Read data lives in the regfile's output register and only moves on an accepted Get,
  // so gating it here keeps D stable while stalled.
  always_comb begin
    a_ready      = (state_q == StIdle) || tl.d_ready;
    tl.a_ready   = a_ready;
    tl.d_valid   = state_q == StResp;
    tl.d_opcode  = d_opcode_q;
    tl.d_param   = 2'b00;
    tl.d_size    = d_size_q;
    tl.d_source  = d_source_q;
    tl.d_sink    = 1'b0;
    tl.d_denied  = d_denied_q;
    tl.d_corrupt = d_denied_q && (d_opcode_q == ACCESS_ACK_DATA);
    tl.d_data    = ((state_q == StResp) && (d_opcode_q == ACCESS_ACK_DATA) && !d_denied_q) ?
                   rf_rdata : '0;
  end

endmodule

// File: tb/tb_tlul_slave.sv
// Directed bench for tlul_slave: a table of single-beat requests plus stall and reset sequences.
module tb_tlul_slave;
  import tlul_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned ZW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlul_slave_if #(.DATA_W(DW), .ADDR_W(AW), .SOURCE_W(SW), .SIZE_W(ZW)) bus ();

  tlul_slave #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (16),
    .BASE_ADDR (32'h0),
    .SOURCE_W  (SW),
    .SIZE_W    (ZW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .tl      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [3:0]  src;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] data, input logic [3:0] src,
                     input logic [2:0] e_op, input logic e_den, input logic e_cor,
                     input logic [31:0] e_data);
    vec_t v;
    v.op = op; v.size = size; v.addr = addr; v.mask = mask; v.data = data; v.src = src;
    v.e_op = e_op; v.e_den = e_den; v.e_cor = e_cor; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  task automatic set_a(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic [3:0] src);
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_param   = 3'd0;
    bus.a_size    = size;
    bus.a_address = addr;
    bus.a_mask    = mask;
    bus.a_data    = data;
    bus.a_source  = src;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.a_valid   = 1'b0;
    bus.a_opcode  = 3'd0;
    bus.a_param   = 3'd0;
    bus.a_size    = '0;
    bus.a_source  = '0;
    bus.a_address = '0;
    bus.a_mask    = '0;
    bus.a_data    = '0;
    bus.d_ready   = 1'b1;

    #2;
    check("reset d_valid", 64'(bus.d_valid), 64'd0);
    check("reset d_opcode", 64'(bus.d_opcode), 64'd0);
    check("reset d_data", 64'(bus.d_data), 64'd0);
    check("reset d_denied", 64'(bus.d_denied), 64'd0);
    check("reset d_corrupt", 64'(bus.d_corrupt), 64'd0);
    check("reset d_source", 64'(bus.d_source), 64'd0);
    check("reset d_size", 64'(bus.d_size), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("post-reset a_ready", 64'(bus.a_ready), 64'd1);

    add(PUT_FULL,    2, 32'h08, 4'hF, 32'hDEADBEEF, 3,  ACCESS_ACK,      0, 0, 32'h0);
    add(GET,         2, 32'h08, 4'hF, 32'h0,        5,  ACCESS_ACK_DATA, 0, 0, 32'hDEADBEEF);
    add(PUT_PARTIAL, 2, 32'h08, 4'h2, 32'h0000AA00, 1,  ACCESS_ACK,      0, 0, 32'h0);
    add(GET,         2, 32'h08, 4'hF, 32'h0,        2,  ACCESS_ACK_DATA, 0, 0, 32'hDEADAAEF);
    add(GET,         2, 32'h40, 4'hF, 32'h0,        7,  ACCESS_ACK_DATA, 1, 1, 32'h0);
    add(GET,         2, 32'h08, 4'hF, 32'h0,        8,  ACCESS_ACK_DATA, 0, 0, 32'hDEADAAEF);
    add(PUT_FULL,    2, 32'h04, 4'hF, 32'h11223344, 9,  ACCESS_ACK,      0, 0, 32'h0);
    add(PUT_FULL,    2, 32'h06, 4'hF, 32'h99999999, 10, ACCESS_ACK,      1, 0, 32'h0);
    add(PUT_FULL,    2, 32'h04, 4'h7, 32'h99999999, 11, ACCESS_ACK,      1, 0, 32'h0);
    add(3'd2,        2, 32'h04, 4'hF, 32'h99999999, 12, ACCESS_ACK,      1, 0, 32'h0);
    add(PUT_PARTIAL, 2, 32'h40, 4'hF, 32'h99999999, 13, ACCESS_ACK,      1, 0, 32'h0);
    add(GET,         2, 32'h04, 4'hF, 32'h0,        14, ACCESS_ACK_DATA, 0, 0, 32'h11223344);
    add(GET,         3, 32'h08, 4'hF, 32'h0,        15, ACCESS_ACK_DATA, 1, 1, 32'h0);
    add(PUT_FULL,    1, 32'h0A, 4'hC, 32'h5A5A0000, 0,  ACCESS_ACK,      0, 0, 32'h0);
    add(PUT_FULL,    0, 32'h09, 4'h2, 32'h00003300, 1,  ACCESS_ACK,      0, 0, 32'h0);
    add(GET,         2, 32'h08, 4'hF, 32'h0,        2,  ACCESS_ACK_DATA, 0, 0, 32'h5A5A33EF);
    add(PUT_FULL,    2, 32'h3C, 4'hF, 32'hCAFEF00D, 3,  ACCESS_ACK,      0, 0, 32'h0);
    add(GET,         2, 32'h3C, 4'hF, 32'h0,        4,  ACCESS_ACK_DATA, 0, 0, 32'hCAFEF00D);
    add(GET,         1, 32'h3E, 4'h0, 32'h0,        5,  ACCESS_ACK_DATA, 0, 0, 32'hCAFEF00D);

    // Each vector is issued on the cycle the previous response is taken.
    for (int i = 0; i < vecs.size(); i++) begin
      set_a(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].src);
      check($sformatf("vec%0d a_ready", i), 64'(bus.a_ready), 64'd1);
      step();
      check($sformatf("vec%0d d_valid", i), 64'(bus.d_valid), 64'd1);
      check($sformatf("vec%0d d_opcode", i), 64'(bus.d_opcode), 64'(vecs[i].e_op));
      check($sformatf("vec%0d d_denied", i), 64'(bus.d_denied), 64'(vecs[i].e_den));
      check($sformatf("vec%0d d_corrupt", i), 64'(bus.d_corrupt), 64'(vecs[i].e_cor));
      check($sformatf("vec%0d d_data", i), 64'(bus.d_data), 64'(vecs[i].e_data));
      check($sformatf("vec%0d d_source", i), 64'(bus.d_source), 64'(vecs[i].src));
      check($sformatf("vec%0d d_size", i), 64'(bus.d_size), 64'(vecs[i].size));
      check($sformatf("vec%0d d_param_sink", i), 64'({bus.d_param, bus.d_sink}), 64'd0);
    end
    bus.a_valid = 1'b0;
    step();
    check("drain d_valid", 64'(bus.d_valid), 64'd0);

    // Stall the D channel for three cycles with a second request waiting.
    bus.d_ready = 1'b0;
    set_a(GET, 2, 32'h08, 4'hF, 32'h0, 6);
    step();
    check("stall first d_valid", 64'(bus.d_valid), 64'd1);
    check("stall a_ready", 64'(bus.a_ready), 64'd0);
    set_a(GET, 2, 32'h3C, 4'hF, 32'h0, 9);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d d_valid", c), 64'(bus.d_valid), 64'd1);
      check($sformatf("stall%0d a_ready", c), 64'(bus.a_ready), 64'd0);
      check($sformatf("stall%0d d_data", c), 64'(bus.d_data), 64'h5A5A33EF);
      check($sformatf("stall%0d d_source", c), 64'(bus.d_source), 64'd6);
      check($sformatf("stall%0d d_opcode", c), 64'(bus.d_opcode), 64'(ACCESS_ACK_DATA));
    end
    bus.d_ready = 1'b1;
    #1;
    check("release a_ready", 64'(bus.a_ready), 64'd1);
    step();
    check("b2b1 d_valid", 64'(bus.d_valid), 64'd1);
    check("b2b1 d_data", 64'(bus.d_data), 64'hCAFEF00D);
    check("b2b1 d_source", 64'(bus.d_source), 64'd9);
    set_a(PUT_FULL, 2, 32'h00, 4'hF, 32'hA5A5A5A5, 10);
    check("b2b2 a_ready", 64'(bus.a_ready), 64'd1);
    step();
    check("b2b2 d_valid", 64'(bus.d_valid), 64'd1);
    check("b2b2 d_opcode", 64'(bus.d_opcode), 64'(ACCESS_ACK));
    check("b2b2 d_source", 64'(bus.d_source), 64'd10);
    bus.a_valid = 1'b0;
    step();
    check("b2b idle d_valid", 64'(bus.d_valid), 64'd0);

    // Reset in the middle of a pending response.
    bus.d_ready = 1'b0;
    set_a(GET, 2, 32'h04, 4'hF, 32'h0, 11);
    step();
    bus.a_valid = 1'b0;
    check("pre-reset d_valid", 64'(bus.d_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid-reset d_valid", 64'(bus.d_valid), 64'd0);
    check("mid-reset d_data", 64'(bus.d_data), 64'd0);
    check("mid-reset d_source", 64'(bus.d_source), 64'd0);
    check("mid-reset d_opcode", 64'(bus.d_opcode), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.d_ready = 1'b1;
    #1;
    check("after-reset a_ready", 64'(bus.a_ready), 64'd1);
    check("after-reset d_valid", 64'(bus.d_valid), 64'd0);
    set_a(GET, 2, 32'h00, 4'hF, 32'h0, 12);
    step();
    check("kept word0 d_data", 64'(bus.d_data), 64'hA5A5A5A5);
    check("kept word0 d_valid", 64'(bus.d_valid), 64'd1);
    set_a(GET, 2, 32'h04, 4'hF, 32'h0, 13);
    step();
    check("kept word1 d_data", 64'(bus.d_data), 64'h11223344);
    check("kept word1 d_source", 64'(bus.d_source), 64'd13);
    bus.a_valid = 1'b0;
    step();
    check("final d_valid", 64'(bus.d_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
